// File: rtl/alu_seq_pkg.sv
// alu_seq_pkg: opcodes, instruction layout and FSM encoding shared by
// the ALU op sequencer and its environment.
package alu_seq_pkg;

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_CMP  = 4'd2;
  localparam logic [3:0] OP_AND  = 4'd3;
  localparam logic [3:0] OP_OR   = 4'd4;
  localparam logic [3:0] OP_NOT  = 4'd5;
  localparam logic [3:0] OP_INC  = 4'd6;
  localparam logic [3:0] OP_DEC  = 4'd7;
  localparam logic [3:0] OP_SHL0 = 4'd8;
  localparam logic [3:0] OP_SHL1 = 4'd9;
  localparam logic [3:0] OP_SHR0 = 4'd10;
  localparam logic [3:0] OP_SHR1 = 4'd11;
  localparam logic [3:0] OP_SLA  = 4'd12;
  localparam logic [3:0] OP_SRA  = 4'd13;
  localparam logic [3:0] OP_ROL  = 4'd14;
  localparam logic [3:0] OP_ROR  = 4'd15;

  localparam int INSN_W  = 13;
  localparam int RES_W   = 5;
  localparam int A_LSB   = 9;
  localparam int B_LSB   = 5;
  localparam int M_LSB   = 1;
  localparam int CIN_BIT = 0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_CAPTURE,
    S_DONE
  } state_e;

endpackage

// File: rtl/alu_op_sequencer_if.sv
// alu_op_sequencer_if: operand/opcode bus to the ALU accumulator and
// its {of, r} response.
interface alu_op_sequencer_if;
  logic [3:0] a;
  logic [3:0] b;
  logic [3:0] m;
  logic       cin;
  logic [3:0] r;
  logic       of;

  modport master (
    output a, b, m, cin,
    input  r, of
  );

  modport slave (
    input  a, b, m, cin,
    output r, of
  );
endinterface

// File: rtl/alu_seq_regfile.sv
// alu_seq_regfile: DEPTH x W array, one synchronous write port and
// one combinational read port; contents are not reset.
module alu_seq_regfile #(
  parameter int DEPTH = 16,
  parameter int W     = 13
) (
  input  logic         clk,
  input  logic         we,
  input  logic [3:0]   waddr,
  input  logic [W-1:0] wdata,
  input  logic [3:0]   raddr,
  output logic [W-1:0] rdata
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[raddr[AW-1:0]];
endmodule

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issues a stored {a,b,m,cin} program to the ALU
// accumulator one entry at a time and records each {of, r}.
module alu_op_sequencer
  import alu_seq_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int RESP_LAT = 1
) (
  input  logic              Clk,
  input  logic              nReset,
  input  logic              prog_we,
  input  logic [3:0]        prog_addr,
  input  logic [INSN_W-1:0] prog_data,
  input  logic [4:0]        len,
  input  logic              start,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  alu_op_sequencer_if.master acc,
  input  logic [3:0]        res_addr,
  output logic [RES_W-1:0]  res_data,
  output logic [4:0]        of_count
);
  localparam logic [4:0] LEN_MAX = 5'(DEPTH);
  localparam logic [2:0] WAIT_LD = 3'(RESP_LAT - 1);

  state_e            state_q;
  logic [3:0]        pc_q;
  logic [4:0]        len_q;
  logic [4:0]        ofc_q;
  logic [2:0]        wcnt_q;
  logic [3:0]        a_q, b_q, m_q;
  logic              cin_q, busy_q, done_q;
  logic [INSN_W-1:0] insn;
  logic [4:0]        len_d;
  logic              last;
  logic              prog_wr;
  logic              res_wr;

  assign len_d   = (len > LEN_MAX) ? LEN_MAX : len;
  assign last    = ({1'b0, pc_q} == len_q - 5'd1);
  assign prog_wr = prog_we && (state_q == S_IDLE);
  // abort in the capture cycle suppresses the result write
  assign res_wr  = (state_q == S_CAPTURE) && !abort;

  alu_seq_regfile #(.DEPTH(DEPTH), .W(INSN_W)) u_prog (
    .clk   (Clk),
    .we    (prog_wr),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (pc_q),
    .rdata (insn)
  );

  alu_seq_regfile #(.DEPTH(DEPTH), .W(RES_W)) u_res (
    .clk   (Clk),
    .we    (res_wr),
    .waddr (pc_q),
    .wdata ({acc.of, acc.r}),
    .raddr (res_addr),
    .rdata (res_data)
  );

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      ofc_q   <= '0;
      wcnt_q  <= '0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      cin_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else if (abort && state_q != S_IDLE) begin
      state_q <= S_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      cin_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start && !abort) begin
            if (len == 5'd0) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              len_q   <= len_d;
              pc_q    <= '0;
              ofc_q   <= '0;
              busy_q  <= 1'b1;
              state_q <= S_ISSUE;
            end
          end
        end
        S_ISSUE: begin
          a_q     <= insn[A_LSB +: 4];
          b_q     <= insn[B_LSB +: 4];
          m_q     <= insn[M_LSB +: 4];
          cin_q   <= insn[CIN_BIT];
          wcnt_q  <= WAIT_LD;
          state_q <= (RESP_LAT == 1) ? S_CAPTURE : S_WAIT;
        end
        S_WAIT: begin
          wcnt_q <= wcnt_q - 3'd1;
          if (wcnt_q <= 3'd1) state_q <= S_CAPTURE;
        end
        S_CAPTURE: begin
          if (acc.of && ofc_q != 5'd31) ofc_q <= ofc_q + 5'd1;
          if (last) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            a_q     <= '0;
            b_q     <= '0;
            m_q     <= '0;
            cin_q   <= 1'b0;
          end else begin
            pc_q    <= pc_q + 4'd1;
            state_q <= S_ISSUE;
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign of_count = ofc_q;
  assign acc.a    = a_q;
  assign acc.b    = b_q;
  assign acc.m    = m_q;
  assign acc.cin  = cin_q;
endmodule
